exe_stage: RTL and testbench

Execute stage of the 5-stage ARM pipeline. It consumes the ID/EX pipeline register outputs and computes Val2 (the shifter operand), the ALU result, the branch target and NZCV. A 16-cycle iterative multiplier stalls upstream while it runs. The EX/MEM register is built in, so all datapath outputs to MEM are registered.

---
 rtl/arm_pkg.sv | 40 ++++
 rtl/exe_stage_if.sv | 42 ++++
 rtl/val2_gen.sv | 36 +++
 rtl/exe_stage.sv | 181 ++++++++++++++++++
 tb/tb_exe_stage.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM execute stage: ALU opcodes, shifter types and
// the iterative-multiplier state encoding.
package arm_pkg;

   typedef enum logic [3:0] {
      CMD_NOP = 4'b0000,
      CMD_MOV = 4'b0001,
      CMD_ADD = 4'b0010,
      CMD_ADC = 4'b0011,
      CMD_SUB = 4'b0100,
      CMD_SBC = 4'b0101,
      CMD_AND = 4'b0110,
      CMD_ORR = 4'b0111,
      CMD_EOR = 4'b1000,
      CMD_MVN = 4'b1001,
      CMD_MUL = 4'b1010
   } exe_cmd_e;

   typedef enum logic [1:0] {
      SH_LSL = 2'b00,
      SH_LSR = 2'b01,
      SH_ASR = 2'b10,
      SH_ROR = 2'b11
   } shift_e;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'b00,
      MUL_BUSY = 2'b01,
      MUL_DONE = 2'b10
   } mul_state_e;

   localparam int MUL_CYCLES = 16;

   function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] amt);
      logic [63:0] t;
      t = {v, v} >> amt;
      return t[31:0];
   endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ID/EX -> EX/MEM bundle of the execute stage. The forwarding inputs exist only
// when FORWARDING_EN is defined.
interface exe_stage_if;
   logic        WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN, imm_IN;
   logic [3:0]  EXE_CMD_IN;
   logic [31:0] PC_IN, Val_Rn_IN, Val_Rm_IN;
   logic [11:0] Shift_operand_IN;
   logic [23:0] Signed_imm_24_IN;
   logic [3:0]  Dest_IN;

   logic        stall, Branch_Taken;
   logic [31:0] Branch_Addr;
   logic [3:0]  Status;
   logic        WB_EN, MEM_R_EN, MEM_W_EN;
   logic [31:0] ALU_Res, Val_Rm;
   logic [3:0]  Dest;

`ifdef FORWARDING_EN
   logic [1:0]  Sel_src1, Sel_src2;
   logic [31:0] MEM_ALU_Res, WB_Value;
`endif

   modport slave (
`ifdef FORWARDING_EN
      input  Sel_src1, Sel_src2, MEM_ALU_Res, WB_Value,
`endif
      input  WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN, imm_IN, EXE_CMD_IN,
             PC_IN, Val_Rn_IN, Val_Rm_IN, Shift_operand_IN, Signed_imm_24_IN, Dest_IN,
      output stall, Branch_Taken, Branch_Addr, Status, WB_EN, MEM_R_EN, MEM_W_EN,
             ALU_Res, Val_Rm, Dest
   );

   modport master (
`ifdef FORWARDING_EN
      output Sel_src1, Sel_src2, MEM_ALU_Res, WB_Value,
`endif
      output WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN, imm_IN, EXE_CMD_IN,
             PC_IN, Val_Rn_IN, Val_Rm_IN, Shift_operand_IN, Signed_imm_24_IN, Dest_IN,
      input  stall, Branch_Taken, Branch_Addr, Status, WB_EN, MEM_R_EN, MEM_W_EN,
             ALU_Res, Val_Rm, Dest
   );
endinterface

// File: rtl/val2_gen.sv
// Shifter-operand generator: rotated 8-bit immediate, sign-extended 12-bit
// memory offset, or the Rm operand shifted by an immediate amount.
module val2_gen
   import arm_pkg::*;
(
   input  logic        imm_i,
   input  logic        mem_en_i,
   input  logic [11:0] shift_operand_i,
   input  logic [31:0] val_rm_i,
   output logic [31:0] val2_o
);

   logic [4:0] sh_amt;
   shift_e     sh_type;

   always_comb begin
      sh_amt  = shift_operand_i[11:7];
      sh_type = shift_e'(shift_operand_i[6:5]);
      val2_o  = '0;
      if (imm_i) begin
         val2_o = ror32({24'b0, shift_operand_i[7:0]}, {shift_operand_i[11:8], 1'b0});
      end else if (mem_en_i) begin
         val2_o = {{20{shift_operand_i[11]}}, shift_operand_i};
      end else begin
         // amount 0 falls through unchanged for every type, ROR included
         case (sh_type)
            SH_LSL:  val2_o = val_rm_i << sh_amt;
            SH_LSR:  val2_o = val_rm_i >> sh_amt;
            SH_ASR:  val2_o = $signed(val_rm_i) >>> sh_amt;
            SH_ROR:  val2_o = ror32(val_rm_i, sh_amt);
            default: val2_o = val_rm_i;
         endcase
      end
   end

endmodule

// File: rtl/exe_stage.sv
// ARM execute stage with built-in EX/MEM register and an iterative multiplier
// that stalls upstream. Optional operand forwarding: FORWARDING_EN.
//
// state    | meaning
// MUL_IDLE | no multiply in flight; a MUL on the inputs stalls and is latched
// MUL_BUSY | retiring MUL_BITS_PER_CYCLE multiplier bits per cycle
// MUL_DONE | product valid; EX/MEM captures it, upstream released
module exe_stage
   import arm_pkg::*;
#(
   parameter int MUL_BITS_PER_CYCLE = 2
) (
   input  logic clk,
   input  logic rst,
   exe_stage_if.slave bus
);

   localparam int MUL_STEPS = 32 / MUL_BITS_PER_CYCLE;

   logic [31:0] op_rn, op_rm, val2;
   logic [32:0] sum;
   logic [31:0] alu_res;
   logic        flag_c, flag_v, is_add, is_sub;
   logic        stall;

   mul_state_e  mul_state_q;
   logic [31:0] mul_acc_q, mul_mcand_q, mul_mplier_q, mul_pp;
   logic [5:0]  mul_cnt_q;

   logic        wb_en_q, wb_en_d, mem_r_q, mem_r_d, mem_w_q, mem_w_d;
   logic [31:0] alu_res_q, alu_res_d, val_rm_q, val_rm_d;
   logic [3:0]  dest_q, dest_d, status_q, status_d;

`ifdef FORWARDING_EN
   always_comb begin
      case (bus.Sel_src1)
         2'b01:   op_rn = bus.MEM_ALU_Res;
         2'b10:   op_rn = bus.WB_Value;
         default: op_rn = bus.Val_Rn_IN;
      endcase
      case (bus.Sel_src2)
         2'b01:   op_rm = bus.MEM_ALU_Res;
         2'b10:   op_rm = bus.WB_Value;
         default: op_rm = bus.Val_Rm_IN;
      endcase
   end
`else
   assign op_rn = bus.Val_Rn_IN;
   assign op_rm = bus.Val_Rm_IN;
`endif

   val2_gen u_val2_gen (
      .imm_i           (bus.imm_IN),
      .mem_en_i        (bus.MEM_R_EN_IN | bus.MEM_W_EN_IN),
      .shift_operand_i (bus.Shift_operand_IN),
      .val_rm_i        (op_rm),
      .val2_o          (val2)
   );

   // Subtraction is a + ~b + 1 so the carry-out is directly NOT borrow.
   always_comb begin
      sum     = '0;
      alu_res = '0;
      is_add  = 1'b0;
      is_sub  = 1'b0;
      flag_c  = status_q[1];
      flag_v  = status_q[0];
      case (bus.EXE_CMD_IN)
         CMD_MOV: alu_res = val2;
         CMD_MVN: alu_res = ~val2;
         CMD_ADD: begin sum = {1'b0, op_rn} + {1'b0, val2}; is_add = 1'b1; end
         CMD_ADC: begin sum = {1'b0, op_rn} + {1'b0, val2} + {32'b0, status_q[1]}; is_add = 1'b1; end
         CMD_SUB: begin sum = {1'b0, op_rn} + {1'b0, ~val2} + 33'd1; is_sub = 1'b1; end
         CMD_SBC: begin sum = {1'b0, op_rn} + {1'b0, ~val2} + {32'b0, status_q[1]}; is_sub = 1'b1; end
         CMD_AND: alu_res = op_rn & val2;
         CMD_ORR: alu_res = op_rn | val2;
         CMD_EOR: alu_res = op_rn ^ val2;
         CMD_MUL: alu_res = mul_acc_q;
         default: alu_res = '0;
      endcase
      if (is_add || is_sub) begin
         alu_res = sum[31:0];
         flag_c  = sum[32];
         flag_v  = is_add ? ((op_rn[31] == val2[31]) && (alu_res[31] != op_rn[31]))
                          : ((op_rn[31] != val2[31]) && (alu_res[31] != op_rn[31]));
      end
   end

   // Gated by reset so an aborted multiply releases upstream immediately.
   assign stall = rst & (((mul_state_q == MUL_IDLE) && (bus.EXE_CMD_IN == CMD_MUL)) ||
                         (mul_state_q == MUL_BUSY));

   assign mul_pp = mul_mcand_q *
                   {{(32-MUL_BITS_PER_CYCLE){1'b0}}, mul_mplier_q[MUL_BITS_PER_CYCLE-1:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mul_state_q  <= MUL_IDLE;
         mul_acc_q    <= '0;
         mul_mcand_q  <= '0;
         mul_mplier_q <= '0;
         mul_cnt_q    <= '0;
      end else begin
         case (mul_state_q)
            MUL_IDLE: begin
               if (bus.EXE_CMD_IN == CMD_MUL) begin
                  mul_acc_q    <= '0;
                  mul_mcand_q  <= op_rn;
                  mul_mplier_q <= op_rm;
                  mul_cnt_q    <= '0;
                  mul_state_q  <= MUL_BUSY;
               end
            end
            MUL_BUSY: begin
               mul_acc_q    <= mul_acc_q + mul_pp;
               mul_mcand_q  <= mul_mcand_q << MUL_BITS_PER_CYCLE;
               mul_mplier_q <= mul_mplier_q >> MUL_BITS_PER_CYCLE;
               mul_cnt_q    <= mul_cnt_q + 6'd1;
               if (mul_cnt_q == 6'(MUL_STEPS - 1)) mul_state_q <= MUL_DONE;
            end
            MUL_DONE: mul_state_q <= MUL_IDLE;
            default:  mul_state_q <= MUL_IDLE;
         endcase
      end
   end

   always_comb begin
      wb_en_d   = wb_en_q;
      mem_r_d   = mem_r_q;
      mem_w_d   = mem_w_q;
      alu_res_d = alu_res_q;
      val_rm_d  = val_rm_q;
      dest_d    = dest_q;
      status_d  = status_q;
      if (stall) begin
         wb_en_d = 1'b0;
         mem_r_d = 1'b0;
         mem_w_d = 1'b0;
      end else begin
         wb_en_d   = bus.WB_EN_IN;
         mem_r_d   = bus.MEM_R_EN_IN;
         mem_w_d   = bus.MEM_W_EN_IN;
         alu_res_d = alu_res;
         val_rm_d  = op_rm;
         dest_d    = bus.Dest_IN;
         if (bus.S_IN) status_d = {alu_res[31], (alu_res == 32'd0), flag_c, flag_v};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_en_q   <= 1'b0;
         mem_r_q   <= 1'b0;
         mem_w_q   <= 1'b0;
         alu_res_q <= '0;
         val_rm_q  <= '0;
         dest_q    <= '0;
         status_q  <= '0;
      end else begin
         wb_en_q   <= wb_en_d;
         mem_r_q   <= mem_r_d;
         mem_w_q   <= mem_w_d;
         alu_res_q <= alu_res_d;
         val_rm_q  <= val_rm_d;
         dest_q    <= dest_d;
         status_q  <= status_d;
      end
   end

   assign bus.stall        = stall;
   assign bus.Branch_Taken = bus.B_IN;
   assign bus.Branch_Addr  = bus.PC_IN + {{6{bus.Signed_imm_24_IN[23]}}, bus.Signed_imm_24_IN, 2'b00};
   assign bus.Status       = status_q;
   assign bus.WB_EN        = wb_en_q;
   assign bus.MEM_R_EN     = mem_r_q;
   assign bus.MEM_W_EN     = mem_w_q;
   assign bus.ALU_Res      = alu_res_q;
   assign bus.Val_Rm       = val_rm_q;
   assign bus.Dest         = dest_q;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed cases, randomized ALU traffic
// against an arithmetic reference model, multiplier stall timing and reset abort.
module tb_exe_stage;
   import arm_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   exe_stage_if bus();
   exe_stage #(.MUL_BITS_PER_CYCLE(2)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_checks = 0;
   int n_pass   = 0;
   logic [3:0]  m_status = 4'b0;
   logic [31:0] m_prev   = 32'b0;

   function automatic logic [31:0] m_ror(input logic [31:0] v, input int r);
      longint unsigned x;
      x = v;
      return 32'((x >> r) | (x << (32 - r)));
   endfunction

   function automatic logic [31:0] m_val2(input logic imm, input logic mem,
                                          input logic [11:0] so, input logic [31:0] rm);
      int s, amt;
      if (imm) return m_ror({24'b0, so[7:0]}, 2 * int'(so[11:8]));
      if (mem) begin
         s = int'(so);
         if (s >= 2048) s = s - 4096;
         return 32'(s);
      end
      amt = int'(so[11:7]);
      case (so[6:5])
         2'b00:   return rm << amt;
         2'b01:   return rm >> amt;
         2'b10: begin s = $signed(rm); return 32'(s >>> amt); end
         default: return m_ror(rm, amt);
      endcase
   endfunction

   // Returns the result and the status that would result if S were set.
   task automatic m_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] st, output logic [31:0] res, output logic [3:0] st_new);
      longint unsigned ua, ub, u;
      longint sa, sb, s;
      logic c, v, arith;
      int cin;
      ua = a; ub = b; sa = longint'($signed(a)); sb = longint'($signed(b));
      cin = int'(st[1]); c = st[1]; v = st[0]; arith = 1'b0; s = 0; u = 0;
      case (cmd)
         4'd1:  res = b;
         4'd9:  res = ~b;
         4'd2:  begin u = ua + ub;       s = sa + sb;       arith = 1'b1; c = (u >> 32) != 0; end
         4'd3:  begin u = ua + ub + cin; s = sa + sb + cin; arith = 1'b1; c = (u >> 32) != 0; end
         4'd4:  begin u = ua - ub;       s = sa - sb;       arith = 1'b1; c = (ua >= ub); end
         4'd5:  begin u = ua - ub - (1 - cin); s = sa - sb - (1 - cin); arith = 1'b1;
                      c = (ua >= ub + longint'(1 - cin)); end
         4'd6:  res = a & b;
         4'd7:  res = a | b;
         4'd8:  res = a ^ b;
         4'd10: res = 32'(ua * ub);
         default: res = 32'b0;
      endcase
      if (arith) begin
         res = 32'(u);
         v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      st_new = {res[31], (res == 32'b0), c, v};
   endtask

   task automatic drive(input logic [3:0] cmd, input logic wb, input logic mr, input logic mw,
                        input logic b, input logic s, input logic imm,
                        input logic [31:0] pc, input logic [31:0] rn, input logic [31:0] rm,
                        input logic [11:0] so, input logic [23:0] off, input logic [3:0] dest);
      bus.EXE_CMD_IN = cmd; bus.WB_EN_IN = wb; bus.MEM_R_EN_IN = mr; bus.MEM_W_EN_IN = mw;
      bus.B_IN = b; bus.S_IN = s; bus.imm_IN = imm; bus.PC_IN = pc; bus.Val_Rn_IN = rn;
      bus.Val_Rm_IN = rm; bus.Shift_operand_IN = so; bus.Signed_imm_24_IN = off; bus.Dest_IN = dest;
`ifdef FORWARDING_EN
      bus.Sel_src1 = 2'b00; bus.Sel_src2 = (($urandom & 1) != 0) ? 2'b11 : 2'b00;
      bus.MEM_ALU_Res = $urandom; bus.WB_Value = $urandom;
`endif
   endtask

   function automatic logic [31:0] pick32();
      logic [31:0] sp [4];
      sp[0] = 32'h0; sp[1] = 32'h7FFFFFFF; sp[2] = 32'h80000000; sp[3] = 32'hFFFFFFFF;
      if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 3)];
      return $urandom;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 12'h0, 24'h0, 4'h0);
      #2 rst = 1'b0;
      tick(); tick();
      n_checks++;
      if ({bus.WB_EN, bus.MEM_R_EN, bus.MEM_W_EN, bus.ALU_Res, bus.Val_Rm, bus.Dest, bus.Status} !== 71'b0)
         $display("FAIL reset_outputs: got res=%h status=%b wb=%b exp all zero", bus.ALU_Res, bus.Status, bus.WB_EN);
      else n_pass++;
      n_checks++;
      if (bus.stall !== 1'b0) $display("FAIL reset_stall: got %b exp 0", bus.stall); else n_pass++;
      #2 rst = 1'b1;
      tick();
   endtask

   task automatic test_directed();
      drive(CMD_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h10, 32'h0, 12'h105, 24'h0, 4'h1);
      tick();
      n_checks++;
      if (bus.ALU_Res !== 32'h40000011) $display("FAIL add_imm_rot: got %h exp 40000011", bus.ALU_Res);
      else n_pass++;

      drive(CMD_SUB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h3, 32'h3, 12'h000, 24'h0, 4'h2);
      tick();
      n_checks++;
      if ({bus.ALU_Res, bus.Status} !== {32'h0, 4'b0110})
         $display("FAIL sub_zero: got res=%h nzcv=%b exp 00000000 0110", bus.ALU_Res, bus.Status);
      else n_pass++;

      drive(CMD_ADC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h1, 32'h0, 12'h001, 24'h0, 4'h3);
      tick();
      n_checks++;
      if (bus.ALU_Res !== 32'h3) $display("FAIL adc_carry_set: got %h exp 00000003", bus.ALU_Res);
      else n_pass++;

      drive(CMD_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h7FFFFFFF, 32'h0, 12'h001, 24'h0, 4'h4);
      tick();
      n_checks++;
      if ({bus.ALU_Res, bus.Status} !== {32'h80000000, 4'b1001})
         $display("FAIL add_overflow: got res=%h nzcv=%b exp 80000000 1001", bus.ALU_Res, bus.Status);
      else n_pass++;

      drive(CMD_ADC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h1, 32'h0, 12'h000, 24'h0, 4'h5);
      tick();
      n_checks++;
      if (bus.ALU_Res !== 32'h1) $display("FAIL adc_carry_clear: got %h exp 00000001", bus.ALU_Res);
      else n_pass++;

      drive(CMD_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h100, 32'h0, 12'hFFC, 24'h0, 4'h6);
      tick();
      n_checks++;
      if ({bus.ALU_Res, bus.MEM_R_EN, bus.Status} !== {32'hFC, 1'b1, 4'b1001})
         $display("FAIL ldr_offset: got res=%h mem_r=%b nzcv=%b exp 000000fc 1 1001",
                  bus.ALU_Res, bus.MEM_R_EN, bus.Status);
      else n_pass++;
      m_status = 4'b1001;
      m_prev   = 32'hFC;
   endtask

   task automatic test_random_alu();
      logic [3:0] cmd, dest, st_new;
      logic [31:0] rn, rm, pc, v2, res;
      logic [11:0] so;
      logic [23:0] off;
      logic imm, mr, mw, s, wb, b;
      for (int i = 0; i < 80; i++) begin
         cmd = 4'($urandom_range(0, 15));
         if (cmd == 4'd10) cmd = 4'd4;
         imm = ($urandom_range(0, 2) == 0);
         mr  = ($urandom_range(0, 3) == 0);
         mw  = !mr && ($urandom_range(0, 3) == 0);
         s = 1'($urandom); wb = 1'($urandom); b = 1'($urandom);
         rn = pick32(); rm = pick32(); pc = $urandom; so = 12'($urandom);
         off = 24'($urandom); dest = 4'($urandom);
         drive(cmd, wb, mr, mw, b, s, imm, pc, rn, rm, so, off, dest);
         v2 = m_val2(imm, mr | mw, so, rm);
         m_alu(cmd, rn, v2, m_status, res, st_new);
         if (s) m_status = st_new;
         #1;
         n_checks++;
         if (bus.stall !== 1'b0) $display("FAIL alu_no_stall: cmd=%h got %b exp 0", cmd, bus.stall);
         else n_pass++;
         tick();
         n_checks++;
         if (bus.ALU_Res !== res)
            $display("FAIL alu_res: cmd=%h rn=%h rm=%h so=%h imm=%b got %h exp %h", cmd, rn, rm, so, imm, bus.ALU_Res, res);
         else n_pass++;
         n_checks++;
         if (bus.Status !== m_status)
            $display("FAIL alu_status: cmd=%h s=%b got %b exp %b", cmd, s, bus.Status, m_status);
         else n_pass++;
         n_checks++;
         if ({bus.WB_EN, bus.MEM_R_EN, bus.MEM_W_EN, bus.Val_Rm, bus.Dest} !== {wb, mr, mw, rm, dest})
            $display("FAIL alu_pipe: got wb=%b mr=%b mw=%b rm=%h dest=%h exp %b %b %b %h %h",
                     bus.WB_EN, bus.MEM_R_EN, bus.MEM_W_EN, bus.Val_Rm, bus.Dest, wb, mr, mw, rm, dest);
         else n_pass++;
         m_prev = res;
      end
   endtask

   task automatic test_branch();
      logic [31:0] pc, exp_addr;
      logic [23:0] off;
      logic b;
      int o;
      for (int i = 0; i < 12; i++) begin
         pc = $urandom; off = 24'($urandom); b = 1'($urandom);
         if (i == 0) off = 24'h800000;
         if (i == 1) off = 24'h7FFFFF;
         drive(4'd0, 1'b0, 1'b0, 1'b0, b, 1'b0, 1'b0, pc, 32'h0, 32'h0, 12'h0, off, 4'h0);
         o = int'(off);
         if (o >= 8388608) o = o - 16777216;
         exp_addr = 32'(longint'(pc) + longint'(o) * 4);
         #1;
         n_checks++;
         if ({bus.Branch_Taken, bus.Branch_Addr} !== {b, exp_addr})
            $display("FAIL branch: pc=%h off=%h got %b %h exp %b %h", pc, off, bus.Branch_Taken, bus.Branch_Addr, b, exp_addr);
         else n_pass++;
      end
      tick();
      m_prev = 32'h0;
   endtask

   task automatic test_mul();
      logic [31:0] rn, rm, prod;
      logic [3:0] exp_st, dest;
      logic s, bubble_bad;
      int cnt;
      for (int i = 0; i < 4; i++) begin
         rn = (i == 0) ? 32'd7 : pick32();
         rm = (i == 0) ? 32'd6 : pick32();
         s  = (i == 0) ? 1'b1 : 1'($urandom);
         dest = 4'($urandom);
         drive(CMD_MUL, 1'b1, 1'b0, 1'b0, 1'b1, s, 1'b0, 32'h1000, rn, rm, 12'h0, 24'hFFFFFF, dest);
         prod = 32'(longint'(rn) * longint'(rm));
         exp_st = s ? {prod[31], (prod == 32'b0), m_status[1:0]} : m_status;
         #1;
         n_checks++;
         if (bus.Branch_Addr !== 32'h0FFC) $display("FAIL branch_during_stall: got %h exp 00000ffc", bus.Branch_Addr);
         else n_pass++;
         cnt = 0; bubble_bad = 1'b0;
         while (bus.stall === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
            if (bus.WB_EN !== 1'b0 || bus.ALU_Res !== m_prev || bus.Status !== m_status) bubble_bad = 1'b1;
         end
         n_checks++;
         if (cnt != MUL_CYCLES + 1) $display("FAIL mul_stall_len: got %0d cycles exp %0d", cnt, MUL_CYCLES + 1);
         else n_pass++;
         n_checks++;
         if (bubble_bad) $display("FAIL mul_bubble: got data/ctrl change during stall exp hold with WB_EN=0");
         else n_pass++;
         tick();
         n_checks++;
         if ({bus.ALU_Res, bus.Status, bus.WB_EN, bus.Val_Rm, bus.Dest} !== {prod, exp_st, 1'b1, rm, dest})
            $display("FAIL mul_result: %h*%h got %h nzcv=%b wb=%b exp %h %b 1", rn, rm, bus.ALU_Res, bus.Status, bus.WB_EN, prod, exp_st);
         else n_pass++;
         m_status = exp_st;
         m_prev   = prod;
      end
   endtask

   task automatic test_reset_mid_mul();
      int cnt;
      drive(CMD_MUL, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'd7, 32'd6, 12'h0, 24'h0, 4'h9);
      tick();
      repeat (7) tick();
      rst = 1'b0;
      #1;
      n_checks++;
      if ({bus.WB_EN, bus.MEM_R_EN, bus.MEM_W_EN, bus.ALU_Res, bus.Val_Rm, bus.Dest, bus.Status, bus.stall} !== 72'b0)
         $display("FAIL reset_abort: got res=%h status=%b stall=%b exp all zero", bus.ALU_Res, bus.Status, bus.stall);
      else n_pass++;
      m_status = 4'b0; m_prev = 32'h0;
      drive(CMD_MUL, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd3, 32'd5, 12'h0, 24'h0, 4'hA);
      #1 rst = 1'b1;
      #1;
      cnt = 0;
      while (bus.stall === 1'b1 && cnt < 40) begin
         cnt++;
         tick();
      end
      n_checks++;
      if (cnt != MUL_CYCLES + 1) $display("FAIL mul_after_reset_len: got %0d exp %0d", cnt, MUL_CYCLES + 1);
      else n_pass++;
      tick();
      n_checks++;
      if ({bus.ALU_Res, bus.Status, bus.WB_EN} !== {32'd15, 4'b0, 1'b1})
         $display("FAIL mul_after_reset: got %h nzcv=%b wb=%b exp 0000000f 0000 1", bus.ALU_Res, bus.Status, bus.WB_EN);
      else n_pass++;
      drive(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 12'h0, 24'h0, 4'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_directed();
      test_random_alu();
      test_branch();
      test_mul();
      test_reset_mid_mul();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
